// File: rtl/iob_ila_seq_pkg.sv
// Shared types and helpers for the ILA trigger-sequencer capture core.
package iob_ila_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PRE  = 3'd1,
    ST_WAIT = 3'd2,
    ST_POST = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  // Upper bounds for the generic field extractor; callers narrow the result.
  localparam int unsigned FIELD_MAX_W = 64;
  localparam int unsigned VEC_MAX_W   = 1024;

  function automatic int unsigned slice_count(input int unsigned sig_w, input int unsigned data_w);
    return (sig_w + data_w - 1) / data_w;
  endfunction

  // Field s of width w from a flattened per-stage vector (low bits hold the field).
  function automatic logic [FIELD_MAX_W-1:0] stage_field(input logic [VEC_MAX_W-1:0] vec,
                                                         input int unsigned s,
                                                         input int unsigned w);
    return FIELD_MAX_W'(vec >> (s * w));
  endfunction

endpackage

// File: rtl/iob_ila_seq_buf.sv
// Simple dual-port sample RAM, one write port and one registered read port.
// Kept standalone so a technology memory macro can drop in.
module iob_ila_seq_buf #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/iob_ila_seq_core.sv
// ILA capture core: circular sample buffer, pre/post trigger windows and a
// multi-stage trigger sequencer. Define ILA_SEQ_EDGE_TRIG_EN for edge-mode stages.
module iob_ila_seq_core
  import iob_ila_seq_pkg::*;
#(
  parameter int unsigned SIGNAL_W  = 32,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned BUFFER_W  = 10,
  parameter int unsigned TRIGGER_W = 4,
  parameter int unsigned STAGES    = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          soft_rst,
  input  logic                          sample_en,
  input  logic [SIGNAL_W-1:0]           signal,
  input  logic [TRIGGER_W-1:0]          trigger,
  input  logic                          arm,
  input  logic [$clog2(STAGES+1)-1:0]   n_stages,
  input  logic [STAGES*TRIGGER_W-1:0]   stage_mask,
  input  logic [STAGES*TRIGGER_W-1:0]   stage_value,
  input  logic [STAGES-1:0]             stage_edge,
  input  logic [BUFFER_W-1:0]           pre_samples,
  input  logic [BUFFER_W-1:0]           post_samples,
  input  logic [BUFFER_W-1:0]           rd_index,
  input  logic [7:0]                    rd_sel,
  output logic [DATA_W-1:0]             rd_data,
  output logic                          busy,
  output logic                          done,
  output logic [$clog2(STAGES+1)-1:0]   stage,
  output logic [BUFFER_W:0]             n_captured
);

  localparam int unsigned STAGE_W  = $clog2(STAGES + 1);
  localparam int unsigned CNT_W    = BUFFER_W + 1;
  localparam int unsigned N_SLICES = slice_count(SIGNAL_W, DATA_W);
  localparam int unsigned PAD_W    = N_SLICES * DATA_W;

  state_t               state_q, state_d;
  logic [BUFFER_W-1:0]  wr_ptr_q;
  logic [BUFFER_W-1:0]  trig_ptr_q, trig_ptr_d;
  logic [BUFFER_W-1:0]  pre_cnt_q, pre_cnt_d;
  logic [BUFFER_W-1:0]  post_cnt_q, post_cnt_d;
  logic [STAGE_W-1:0]   stage_q, stage_d, last_stage_c;
  logic [CNT_W-1:0]     n_captured_d;
  logic [BUFFER_W-1:0]  room_c, eff_post_c;
  logic [STAGES-1:0]    match_c, hit_c;
  logic                 cur_hit_c, wr_en_c;
  logic [BUFFER_W-1:0]  rd_addr_c;
  logic [SIGNAL_W-1:0]  rd_word_q;
  logic [7:0]           rd_sel_q;
  logic                 rd_valid_q;
  logic [PAD_W-1:0]     rd_padded_c;

  assign stage = stage_q;

  // Clamp the programmed stage count to 1..STAGES
  always_comb begin
    if (n_stages == '0)                       last_stage_c = '0;
    else if (n_stages > STAGE_W'(STAGES))     last_stage_c = STAGE_W'(STAGES - 1);
    else                                      last_stage_c = n_stages - STAGE_W'(1);
  end

  // (2^BUFFER_W - 1) - pre is simply the bitwise inverse of pre
  assign room_c     = ~pre_samples;
  assign eff_post_c = (post_samples < room_c) ? post_samples : room_c;

  always_comb begin
    match_c = '0;
    for (int unsigned s = 0; s < STAGES; s++) begin
      match_c[s] = ((trigger ^ TRIGGER_W'(stage_field(VEC_MAX_W'(stage_value), s, TRIGGER_W)))
                   & TRIGGER_W'(stage_field(VEC_MAX_W'(stage_mask), s, TRIGGER_W))) == '0;
    end
  end

`ifdef ILA_SEQ_EDGE_TRIG_EN
  logic [STAGES-1:0] prev_match_q;

  assign hit_c = match_c & (~stage_edge | ~prev_match_q);

  // Preset to all-ones so a condition already true at arm is not an edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst)            prev_match_q <= '1;
    else if (soft_rst)  prev_match_q <= '1;
    else if (sample_en) prev_match_q <= arm ? '1 : match_c;
  end
`else
  logic [STAGES-1:0] unused_stage_edge;
  assign unused_stage_edge = stage_edge;
  assign hit_c             = match_c;
`endif

  always_comb begin
    cur_hit_c = 1'b0;
    for (int unsigned s = 0; s < STAGES; s++) begin
      if (stage_q == STAGE_W'(s)) cur_hit_c = hit_c[s];
    end
  end

  // Next-state logic; nothing advances without sample_en
  always_comb begin
    state_d      = state_q;
    stage_d      = stage_q;
    pre_cnt_d    = pre_cnt_q;
    post_cnt_d   = post_cnt_q;
    trig_ptr_d   = trig_ptr_q;
    n_captured_d = n_captured;
    wr_en_c      = 1'b0;
    if (sample_en) begin
      if (arm) begin
        stage_d      = '0;
        pre_cnt_d    = '0;
        post_cnt_d   = '0;
        n_captured_d = '0;
        state_d      = (pre_samples == '0) ? ST_WAIT : ST_PRE;
      end else begin
        unique case (state_q)
          ST_PRE: begin
            wr_en_c   = 1'b1;
            pre_cnt_d = pre_cnt_q + BUFFER_W'(1);
            if (pre_cnt_d == pre_samples) state_d = ST_WAIT;
          end
          ST_WAIT: begin
            wr_en_c = 1'b1;
            if (cur_hit_c) begin
              if (stage_q == last_stage_c) begin
                trig_ptr_d = wr_ptr_q;
                post_cnt_d = '0;
                if (eff_post_c == '0) begin
                  state_d      = ST_DONE;
                  n_captured_d = CNT_W'(pre_samples) + CNT_W'(1);
                end else begin
                  state_d = ST_POST;
                end
              end else begin
                stage_d = stage_q + STAGE_W'(1);
              end
            end
          end
          ST_POST: begin
            wr_en_c    = 1'b1;
            post_cnt_d = post_cnt_q + BUFFER_W'(1);
            if (post_cnt_d == eff_post_c) begin
              state_d      = ST_DONE;
              n_captured_d = CNT_W'(pre_samples) + CNT_W'(eff_post_c) + CNT_W'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      wr_ptr_q   <= '0;
      trig_ptr_q <= '0;
      pre_cnt_q  <= '0;
      post_cnt_q <= '0;
      stage_q    <= '0;
      n_captured <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else if (soft_rst) begin
      state_q    <= ST_IDLE;
      wr_ptr_q   <= '0;
      trig_ptr_q <= '0;
      pre_cnt_q  <= '0;
      post_cnt_q <= '0;
      stage_q    <= '0;
      n_captured <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_en_c ? wr_ptr_q + BUFFER_W'(1) : wr_ptr_q;
      trig_ptr_q <= trig_ptr_d;
      pre_cnt_q  <= pre_cnt_d;
      post_cnt_q <= post_cnt_d;
      stage_q    <= stage_d;
      n_captured <= n_captured_d;
      busy       <= (state_d == ST_PRE) || (state_d == ST_WAIT) || (state_d == ST_POST);
      done       <= (state_d == ST_DONE);
    end
  end

  // Readback is relative to the oldest kept sample
  assign rd_addr_c = trig_ptr_q - pre_samples + rd_index;

  iob_ila_seq_buf #(
    .DATA_W (SIGNAL_W),
    .ADDR_W (BUFFER_W)
  ) u_buf (
    .clk   (clk),
    .we    (wr_en_c & ~soft_rst),
    .waddr (wr_ptr_q),
    .wdata (signal),
    .raddr (rd_addr_c),
    .rdata (rd_word_q)
  );

  // Slice select is delayed to line up with the registered RAM read
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_sel_q   <= '0;
      rd_valid_q <= 1'b0;
    end else if (soft_rst) begin
      rd_sel_q   <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_sel_q   <= rd_sel;
      rd_valid_q <= 1'b1;
    end
  end

  always_comb begin
    rd_padded_c                 = '0;
    rd_padded_c[SIGNAL_W-1:0]   = rd_word_q;
    rd_data                     = '0;
    if (rd_valid_q) begin
      for (int unsigned i = 0; i < N_SLICES; i++) begin
        if (rd_sel_q == 8'(i)) rd_data = rd_padded_c[i*DATA_W +: DATA_W];
      end
    end
  end

endmodule

// File: tb/tb_iob_ila_seq_core.sv
// Directed self-checking bench for iob_ila_seq_core (16-deep buffer, 40-bit
// signal read as two 32-bit slices). Edge checks follow ILA_SEQ_EDGE_TRIG_EN.
module tb_iob_ila_seq_core;

  localparam int unsigned SIGNAL_W  = 40;
  localparam int unsigned DATA_W    = 32;
  localparam int unsigned BUFFER_W  = 4;
  localparam int unsigned TRIGGER_W = 4;
  localparam int unsigned STAGES    = 4;

  logic                        clk = 1'b0;
  logic                        rst = 1'b1;
  logic                        soft_rst = 1'b0;
  logic                        sample_en = 1'b0;
  logic [SIGNAL_W-1:0]         signal = '0;
  logic [TRIGGER_W-1:0]        trigger = '0;
  logic                        arm = 1'b0;
  logic [2:0]                  n_stages = 3'd1;
  logic [STAGES*TRIGGER_W-1:0] stage_mask = '0;
  logic [STAGES*TRIGGER_W-1:0] stage_value = '0;
  logic [STAGES-1:0]           stage_edge = '0;
  logic [BUFFER_W-1:0]         pre_samples = '0;
  logic [BUFFER_W-1:0]         post_samples = '0;
  logic [BUFFER_W-1:0]         rd_index = '0;
  logic [7:0]                  rd_sel = '0;
  logic [DATA_W-1:0]           rd_data;
  logic                        busy;
  logic                        done;
  logic [2:0]                  stage;
  logic [BUFFER_W:0]           n_captured;

  int errors = 0;
  int checks = 0;

  iob_ila_seq_core #(
    .SIGNAL_W (SIGNAL_W), .DATA_W (DATA_W), .BUFFER_W (BUFFER_W),
    .TRIGGER_W(TRIGGER_W), .STAGES (STAGES)
  ) dut (
    .clk(clk), .rst(rst), .soft_rst(soft_rst), .sample_en(sample_en),
    .signal(signal), .trigger(trigger), .arm(arm), .n_stages(n_stages),
    .stage_mask(stage_mask), .stage_value(stage_value), .stage_edge(stage_edge),
    .pre_samples(pre_samples), .post_samples(post_samples),
    .rd_index(rd_index), .rd_sel(rd_sel), .rd_data(rd_data),
    .busy(busy), .done(done), .stage(stage), .n_captured(n_captured)
  );

  always #5 clk = ~clk;

  // One clock with the given inputs; sample value k encodes as {C3^k[7:0], k}
  task automatic cyc(input logic en, input logic [31:0] k, input logic [3:0] trig, input logic a);
    sample_en = en;
    signal    = {8'hC3 ^ k[7:0], k};
    trigger   = trig;
    arm       = a;
    @(posedge clk);
    #1;
    sample_en = 1'b0;
    arm       = 1'b0;
  endtask

  task automatic read_word(input int idx, input logic [7:0] sel, output logic [31:0] d);
    rd_index = 4'(idx);
    rd_sel   = sel;
    @(posedge clk);
    #1;
    d = rd_data;
  endtask

  task automatic set_cfg(input logic [3:0] pre, input logic [3:0] post, input logic [2:0] ns,
                         input logic [15:0] mask, input logic [15:0] value, input logic [3:0] edg);
    pre_samples  = pre;
    post_samples = post;
    n_stages     = ns;
    stage_mask   = mask;
    stage_value  = value;
    stage_edge   = edg;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({busy, done, stage, n_captured, rd_data} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: busy=%0b done=%0b stage=%0d n_cap=%0d rd=%h want all 0",
               busy, done, stage, n_captured, rd_data);
    end
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    logic [31:0] d;
    set_cfg(4'd3, 4'd4, 3'd1, 16'h0001, 16'h0001, 4'h0);
    cyc(1'b1, 0, 4'h0, 1'b1);
    for (int k = 1; k <= 14; k++) begin
      cyc(1'b1, 32'(k), (k == 10) ? 4'h1 : 4'h0, 1'b0);
      if (k == 13) begin
        checks++;
        if ({busy, done} !== 2'b10) begin
          errors++;
          $display("FAIL basic_not_done_early: busy,done=%b want 10", {busy, done});
        end
      end
    end
    checks++;
    if ({busy, done, n_captured} !== {2'b01, 5'd8}) begin
      errors++;
      $display("FAIL basic_done: busy=%0b done=%0b n_cap=%0d want 0 1 8", busy, done, n_captured);
    end
    for (int i = 0; i < 8; i++) begin
      read_word(i, 8'd0, d);
      checks++;
      if (d !== 32'(7 + i)) begin
        errors++;
        $display("FAIL basic_rd[%0d]: got %0d want %0d", i, d, 7 + i);
      end
    end
    read_word(3, 8'd1, d);
    checks++;
    if (d !== 32'h0000_00C9) begin
      errors++;
      $display("FAIL basic_slice1: got %h want 000000c9", d);
    end
    read_word(3, 8'd2, d);
    checks++;
    if (d !== 32'h0) begin
      errors++;
      $display("FAIL basic_slice_oob: got %h want 0", d);
    end
  endtask

  task automatic test_multi_stage();
    logic [31:0] d;
    logic [3:0]  trig_seq [6]  = '{4'd1, 4'd3, 4'd2, 4'd1, 4'd2, 4'd3};
    logic [2:0]  stage_exp [6] = '{3'd1, 3'd1, 3'd2, 3'd2, 3'd2, 3'd2};
    set_cfg(4'd2, 4'd2, 3'd3, 16'h0FFF, 16'h0321, 4'h0);
    cyc(1'b1, 100, 4'h0, 1'b1);
    cyc(1'b1, 101, 4'h1, 1'b0);
    cyc(1'b1, 102, 4'h1, 1'b0);
    checks++;
    if (stage !== 3'd0) begin
      errors++;
      $display("FAIL ms_pre_ignores_trig: stage=%0d want 0", stage);
    end
    for (int i = 0; i < 6; i++) begin
      cyc(1'b1, 32'(103 + i), trig_seq[i], 1'b0);
      checks++;
      if (stage !== stage_exp[i] || done !== 1'b0) begin
        errors++;
        $display("FAIL ms_stage[%0d]: stage=%0d done=%0b want %0d 0", i, stage, done, stage_exp[i]);
      end
    end
    cyc(1'b1, 109, 4'h0, 1'b0);
    cyc(1'b1, 110, 4'h0, 1'b0);
    checks++;
    if ({done, n_captured} !== {1'b1, 5'd5}) begin
      errors++;
      $display("FAIL ms_done: done=%0b n_cap=%0d want 1 5", done, n_captured);
    end
    for (int i = 0; i < 5; i++) begin
      read_word(i, 8'd0, d);
      checks++;
      if (d !== 32'(106 + i)) begin
        errors++;
        $display("FAIL ms_rd[%0d]: got %0d want %0d", i, d, 106 + i);
      end
    end
  endtask

  task automatic test_wrap();
    logic [31:0] d;
    set_cfg(4'd10, 4'd12, 3'd1, 16'h0001, 16'h0001, 4'h0);
    cyc(1'b1, 200, 4'h0, 1'b1);
    for (int k = 201; k <= 219; k++) begin
      cyc(1'b1, 32'(k), (k == 214) ? 4'h1 : 4'h0, 1'b0);
      if (k == 218) begin
        checks++;
        if (done !== 1'b0) begin
          errors++;
          $display("FAIL wrap_not_done_early: done=%0b want 0", done);
        end
      end
    end
    checks++;
    if ({done, n_captured} !== {1'b1, 5'd16}) begin
      errors++;
      $display("FAIL wrap_done: done=%0b n_cap=%0d want 1 16", done, n_captured);
    end
    for (int i = 0; i < 16; i++) begin
      read_word(i, 8'd0, d);
      checks++;
      if (d !== 32'(204 + i)) begin
        errors++;
        $display("FAIL wrap_rd[%0d]: got %0d want %0d", i, d, 204 + i);
      end
    end
  endtask

  task automatic test_en_toggle();
    logic [31:0] d;
    set_cfg(4'd3, 4'd4, 3'd1, 16'h0001, 16'h0001, 4'h0);
    for (int k = 0; k <= 14; k++) begin
      cyc(1'b1, 32'(k), (k == 10) ? 4'h1 : 4'h0, k == 0);
      cyc(1'b0, 32'hDEAD, 4'hF, k == 5);
      checks++;
      if ({busy, done} !== ((k == 14) ? 2'b01 : 2'b10)) begin
        errors++;
        $display("FAIL en_hold[%0d]: busy,done=%b want %b", k, {busy, done},
                 (k == 14) ? 2'b01 : 2'b10);
      end
    end
    checks++;
    if (n_captured !== 5'd8) begin
      errors++;
      $display("FAIL en_ncap: got %0d want 8", n_captured);
    end
    for (int i = 0; i < 8; i++) begin
      read_word(i, 8'd0, d);
      checks++;
      if (d !== 32'(7 + i)) begin
        errors++;
        $display("FAIL en_rd[%0d]: got %0d want %0d", i, d, 7 + i);
      end
    end
  endtask

  task automatic test_arm_restart();
    set_cfg(4'd1, 4'd8, 3'd2, 16'h00FF, 16'h0021, 4'h0);
    rd_index = 4'd0;
    rd_sel   = 8'd1;
    cyc(1'b1, 300, 4'h0, 1'b1);
    cyc(1'b1, 301, 4'h0, 1'b0);
    cyc(1'b1, 302, 4'h1, 1'b0);
    cyc(1'b1, 303, 4'h2, 1'b0);
    cyc(1'b1, 304, 4'h0, 1'b0);
    cyc(1'b1, 305, 4'h0, 1'b0);
    checks++;
    if ({busy, done, stage} !== {2'b10, 3'd1}) begin
      errors++;
      $display("FAIL post_state: busy=%0b done=%0b stage=%0d want 1 0 1", busy, done, stage);
    end
    cyc(1'b1, 306, 4'h0, 1'b1);
    checks++;
    if ({busy, done, stage, n_captured} !== {2'b10, 3'd0, 5'd0}) begin
      errors++;
      $display("FAIL rearm_post: busy=%0b done=%0b stage=%0d n_cap=%0d want 1 0 0 0",
               busy, done, stage, n_captured);
    end
    cyc(1'b1, 307, 4'h1, 1'b0);
    cyc(1'b1, 308, 4'h1, 1'b0);
    checks++;
    if ({busy, stage} !== {1'b1, 3'd1}) begin
      errors++;
      $display("FAIL rearm_wait: busy=%0b stage=%0d want 1 1", busy, stage);
    end
    checks++;
    if (rd_data === '0) begin
      errors++;
      $display("FAIL rd_before_rst: got %h want nonzero upper slice", rd_data);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({busy, done, stage, n_captured, rd_data} !== '0) begin
      errors++;
      $display("FAIL async_rst: busy=%0b done=%0b stage=%0d n_cap=%0d rd=%h want all 0",
               busy, done, stage, n_captured, rd_data);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    cyc(1'b1, 400, 4'h0, 1'b1);
    soft_rst = 1'b1;
    cyc(1'b1, 401, 4'h0, 1'b1);
    soft_rst = 1'b0;
    checks++;
    if ({busy, done, stage, rd_data} !== '0) begin
      errors++;
      $display("FAIL soft_rst_wins: busy=%0b done=%0b stage=%0d rd=%h want all 0",
               busy, done, stage, rd_data);
    end
    cyc(1'b1, 402, 4'h1, 1'b0);
    checks++;
    if ({busy, done} !== 2'b00) begin
      errors++;
      $display("FAIL idle_after_soft: busy,done=%b want 00", {busy, done});
    end
  endtask

  task automatic test_edge_trig();
    logic [31:0] d;
    set_cfg(4'd0, 4'd0, 3'd1, 16'h0001, 16'h0001, 4'h1);
    cyc(1'b1, 500, 4'h1, 1'b1);
    checks++;
    if ({busy, done} !== 2'b10) begin
      errors++;
      $display("FAIL edge_arm: busy,done=%b want 10", {busy, done});
    end
`ifdef ILA_SEQ_EDGE_TRIG_EN
    for (int k = 501; k <= 503; k++) begin
      cyc(1'b1, 32'(k), 4'h1, 1'b0);
      checks++;
      if ({busy, done} !== 2'b10) begin
        errors++;
        $display("FAIL edge_held_high[%0d]: busy,done=%b want 10", k, {busy, done});
      end
    end
    cyc(1'b1, 504, 4'h0, 1'b0);
    checks++;
    if ({busy, done} !== 2'b10) begin
      errors++;
      $display("FAIL edge_low: busy,done=%b want 10", {busy, done});
    end
`endif
    cyc(1'b1, 505, 4'h1, 1'b0);
    checks++;
    if ({busy, done, n_captured} !== {2'b01, 5'd1}) begin
      errors++;
      $display("FAIL edge_trig: busy=%0b done=%0b n_cap=%0d want 0 1 1", busy, done, n_captured);
    end
    read_word(0, 8'd0, d);
    checks++;
    if (d !== 32'd505) begin
      errors++;
      $display("FAIL edge_rd: got %0d want 505", d);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_multi_stage();
    test_wrap();
    test_en_toggle();
    test_arm_restart();
    test_edge_trig();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
